// File: rtl/sprite_overlay.sv
// rtl/sprite_overlay.sv - four-sprite overlay on a 4:4:4 RGB stream, 2-cycle pixel latency
// Optional collision detection is built when SPRITE_OVERLAY_COLLISION_EN is defined.
module sprite_overlay #(
    parameter int NUM_SPRITES = 4,
    parameter int LATENCY     = 2
) (
    input  logic                   clkPixel,
    input  logic                   reset,
    input  logic [3:0]             bgRed,
    input  logic [3:0]             bgGreen,
    input  logic [3:0]             bgBlue,
    input  logic                   hsyncIn,
    input  logic                   vsyncIn,
    input  logic                   videoActiveIn,
    input  logic [9:0]             hPos,
    input  logic [9:0]             vPos,
    input  logic                   frameStart,
    input  logic                   regWrite,
    input  logic [3:0]             regAddr,
    input  logic [15:0]            regData,
    output logic [3:0]             red,
    output logic [3:0]             green,
    output logic [3:0]             blue,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   videoActive,
    output logic [NUM_SPRITES-1:0] collision,
    output logic                   collisionIrq
);

    logic [9:0]  x_sh     [NUM_SPRITES];
    logic [9:0]  y_sh     [NUM_SPRITES];
    logic [5:0]  size_sh  [NUM_SPRITES];
    logic [11:0] color_sh [NUM_SPRITES];
    logic        en_sh    [NUM_SPRITES];

    logic [9:0]  x_act     [NUM_SPRITES];
    logic [9:0]  y_act     [NUM_SPRITES];
    logic [5:0]  size_act  [NUM_SPRITES];
    logic [11:0] color_act [NUM_SPRITES];
    logic        en_act    [NUM_SPRITES];

    logic [NUM_SPRITES-1:0] hit;
    logic [NUM_SPRITES-1:0] s1_hit;
    logic [11:0]            s1_bg;
    logic                   s1_hs;
    logic                   s1_vs;
    logic                   s1_va;
    logic [11:0]            mux_rgb;

    logic unused_bits;
    assign unused_bits = ^regData[14:12];

    // Commit copies the pre-edge shadow, so a same-cycle write waits a frame.
    always_ff @(posedge clkPixel) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                x_sh[i]      <= '0;
                y_sh[i]      <= '0;
                size_sh[i]   <= '0;
                color_sh[i]  <= '0;
                en_sh[i]     <= 1'b0;
                x_act[i]     <= '0;
                y_act[i]     <= '0;
                size_act[i]  <= '0;
                color_act[i] <= '0;
                en_act[i]    <= 1'b0;
            end
        end else begin
            if (frameStart) begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    x_act[i]     <= x_sh[i];
                    y_act[i]     <= y_sh[i];
                    size_act[i]  <= size_sh[i];
                    color_act[i] <= color_sh[i];
                    en_act[i]    <= en_sh[i];
                end
            end
            if (regWrite) begin
                case (regAddr[1:0])
                    2'd0: x_sh[regAddr[3:2]]    <= regData[9:0];
                    2'd1: y_sh[regAddr[3:2]]    <= regData[9:0];
                    2'd2: size_sh[regAddr[3:2]] <= regData[5:0];
                    default: begin
                        color_sh[regAddr[3:2]] <= regData[11:0];
                        en_sh[regAddr[3:2]]    <= regData[15];
                    end
                endcase
            end
        end
    end

    // 11-bit compares keep sprites near the right/bottom edge from wrapping to 0.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            hit[i] = en_act[i]
                && ({1'b0, hPos} >= {1'b0, x_act[i]})
                && ({1'b0, hPos} < ({1'b0, x_act[i]} + {5'd0, size_act[i]} + 11'd1))
                && ({1'b0, vPos} >= {1'b0, y_act[i]})
                && ({1'b0, vPos} < ({1'b0, y_act[i]} + {5'd0, size_act[i]} + 11'd1));
        end
    end

    always_ff @(posedge clkPixel) begin
        if (reset) begin
            s1_hit <= '0;
            s1_bg  <= '0;
            s1_hs  <= 1'b1;
            s1_vs  <= 1'b1;
            s1_va  <= 1'b0;
        end else begin
            s1_hit <= hit;
            s1_bg  <= {bgRed, bgGreen, bgBlue};
            s1_hs  <= hsyncIn;
            s1_vs  <= vsyncIn;
            s1_va  <= videoActiveIn;
        end
    end

    // Scan from the top index down so the lowest-index hit is applied last.
    always_comb begin
        mux_rgb = '0;
        if (s1_va) begin
            mux_rgb = s1_bg;
            for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
                if (s1_hit[i]) begin
                    mux_rgb = color_act[i];
                end
            end
        end
    end

    always_ff @(posedge clkPixel) begin
        if (reset) begin
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            videoActive <= 1'b0;
        end else begin
            red         <= mux_rgb[11:8];
            green       <= mux_rgb[7:4];
            blue        <= mux_rgb[3:0];
            hsync       <= s1_hs;
            vsync       <= s1_vs;
            videoActive <= s1_va;
        end
    end

`ifdef SPRITE_OVERLAY_COLLISION_EN
    logic [NUM_SPRITES-1:0] coll_acc;
    logic [NUM_SPRITES-1:0] coll_q;
    logic                   irq_q;
    logic                   multi_hit;

    // Clearing the lowest set bit leaves something only when two or more hit.
    assign multi_hit = |(hit & (hit - 1'b1));

    always_ff @(posedge clkPixel) begin
        if (reset) begin
            coll_acc <= '0;
            coll_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            irq_q <= 1'b0;
            if (frameStart) begin
                coll_q   <= coll_acc;
                coll_acc <= '0;
                irq_q    <= |coll_acc;
            end else if (videoActiveIn && multi_hit) begin
                coll_acc <= coll_acc | hit;
            end
        end
    end

    assign collision    = coll_q;
    assign collisionIrq = irq_q;
`else
    assign collision    = '0;
    assign collisionIrq = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_overlay.sv
// tb/tb_sprite_overlay.sv - randomized bench for sprite_overlay with a behavioural model
module tb_sprite_overlay;

    logic        clkPixel = 1'b0;
    logic        reset;
    logic [3:0]  bgRed, bgGreen, bgBlue;
    logic        hsyncIn, vsyncIn, videoActiveIn;
    logic [9:0]  hPos, vPos;
    logic        frameStart, regWrite;
    logic [3:0]  regAddr;
    logic [15:0] regData;
    logic [3:0]  red, green, blue;
    logic        hsync, vsync, videoActive;
    logic [3:0]  collision;
    logic        collisionIrq;

    always #5 clkPixel = ~clkPixel;

    sprite_overlay dut (
        .clkPixel(clkPixel), .reset(reset),
        .bgRed(bgRed), .bgGreen(bgGreen), .bgBlue(bgBlue),
        .hsyncIn(hsyncIn), .vsyncIn(vsyncIn), .videoActiveIn(videoActiveIn),
        .hPos(hPos), .vPos(vPos), .frameStart(frameStart),
        .regWrite(regWrite), .regAddr(regAddr), .regData(regData),
        .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .videoActive(videoActive),
        .collision(collision), .collisionIrq(collisionIrq)
    );

    int checks = 0;
    int errors = 0;
    bit run = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model state: sprite parameters as plain integers, outputs as a two-entry delay line.
    localparam logic [14:0] RST_OUT = {12'h000, 1'b1, 1'b1, 1'b0};
    int          mx[4], my[4], msz[4], ax[4], ay[4], asz[4];
    logic [11:0] mcol[4], acol[4];
    bit          men[4], aen[4];
    logic [14:0] p1, p2;
    logic [3:0]  macc, mcoll, hv;
    bit          mirq;
    logic [11:0] rgb;
    int          cnt, k;

    always @(posedge clkPixel) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                mx[i] = 0; my[i] = 0; msz[i] = 0; mcol[i] = 0; men[i] = 0;
                ax[i] = 0; ay[i] = 0; asz[i] = 0; acol[i] = 0; aen[i] = 0;
            end
            p1 = RST_OUT; p2 = RST_OUT;
            macc = 0; mcoll = 0; mirq = 0;
        end else begin
            hv = 0; cnt = 0;
            for (int i = 0; i < 4; i++) begin
                hv[i] = aen[i] && int'(hPos) >= ax[i] && int'(hPos) < ax[i] + asz[i] + 1
                        && int'(vPos) >= ay[i] && int'(vPos) < ay[i] + asz[i] + 1;
                if (hv[i]) cnt++;
            end
            rgb = videoActiveIn ? {bgRed, bgGreen, bgBlue} : 12'h000;
            if (videoActiveIn) begin
                for (int i = 0; i < 4; i++) begin
                    if (hv[i]) begin
                        rgb = acol[i];
                        break;
                    end
                end
            end
            p2 = p1;
            p1 = {rgb, hsyncIn, vsyncIn, videoActiveIn};
`ifdef SPRITE_OVERLAY_COLLISION_EN
            mirq = frameStart && (macc != 0);
            if (frameStart) begin
                mcoll = macc;
                macc = 0;
            end else if (videoActiveIn && cnt >= 2) begin
                macc = macc | hv;
            end
`endif
            if (frameStart) begin
                for (int i = 0; i < 4; i++) begin
                    ax[i] = mx[i]; ay[i] = my[i]; asz[i] = msz[i];
                    acol[i] = mcol[i]; aen[i] = men[i];
                end
            end
            if (regWrite) begin
                k = int'(regAddr[3:2]);
                case (regAddr[1:0])
                    2'd0: mx[k] = int'(regData[9:0]);
                    2'd1: my[k] = int'(regData[9:0]);
                    2'd2: msz[k] = int'(regData[5:0]);
                    default: begin
                        mcol[k] = regData[11:0];
                        men[k] = regData[15];
                    end
                endcase
            end
        end
    end

    always @(negedge clkPixel) begin
        if (run) begin
            checks++;
            if ({red, green, blue, hsync, vsync, videoActive} !== p2) begin
                errors++;
                $display("FAIL pixel_out t=%0t: got %h expected %h", $time,
                         {red, green, blue, hsync, vsync, videoActive}, p2);
            end
            checks++;
            if ({collision, collisionIrq} !== {mcoll, mirq}) begin
                errors++;
                $display("FAIL collision_out t=%0t: got %h expected %h", $time,
                         {collision, collisionIrq}, {mcoll, mirq});
            end
        end
    end

    task automatic tick();
        @(posedge clkPixel);
        #2;
    endtask

    task automatic write_reg(input logic [1:0] idx, input logic [1:0] field, input logic [15:0] data);
        regWrite = 1'b1;
        regAddr = {idx, field};
        regData = data;
        tick();
        regWrite = 1'b0;
    endtask

    task automatic sprite(input logic [1:0] idx, input logic [9:0] x, input logic [9:0] y,
                          input logic [5:0] size, input logic [11:0] col);
        write_reg(idx, 2'd0, {6'd0, x});
        write_reg(idx, 2'd1, {6'd0, y});
        write_reg(idx, 2'd2, {10'd0, size});
        write_reg(idx, 2'd3, {4'h8, col});
    endtask

    task automatic frame_start();
        videoActiveIn = 1'b0;
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
    endtask

    task automatic pix_check(input string name, input logic [9:0] h, input logic [9:0] v,
                             input logic [11:0] exp);
        hPos = h; vPos = v;
        videoActiveIn = 1'b1;
        {bgRed, bgGreen, bgBlue} = 12'h123;
        hsyncIn = 1'b1; vsyncIn = 1'b1;
        tick();
        tick();
        check(name, {red, green, blue}, exp);
    endtask

    logic [3:0] exp_coll;
    logic       exp_irq;
    int         r;

    initial begin
        reset = 1'b1;
        {bgRed, bgGreen, bgBlue} = 12'h000;
        hsyncIn = 1'b1; vsyncIn = 1'b1; videoActiveIn = 1'b0;
        hPos = 0; vPos = 0;
        frameStart = 0; regWrite = 0; regAddr = 0; regData = 0;
        tick();
        run = 1'b1;
        tick();
        check("reset_rgb", {red, green, blue}, 12'h000);
        check("reset_sync", {hsync, vsync, videoActive}, 3'b110);
        check("reset_coll", {collision, collisionIrq}, 5'h00);

        reset = 1'b0;
        {bgRed, bgGreen, bgBlue} = 12'h5A3;
        videoActiveIn = 1'b1; hsyncIn = 1'b0; vsyncIn = 1'b1;
        tick();
        check("hsync_lat1", hsync, 1'b1);
        tick();
        check("bg_pass", {red, green, blue}, 12'h5A3);
        check("hsync_lat2", hsync, 1'b0);
        hsyncIn = 1'b1;
        tick();
        check("hsync_hold", hsync, 1'b0);
        tick();
        check("hsync_rise", hsync, 1'b1);

        sprite(2'd0, 10'd100, 10'd50, 6'd7, 12'hF00);
        frame_start();
        pix_check("s0_left", 100, 50, 12'hF00);
        pix_check("s0_right", 107, 50, 12'hF00);
        pix_check("s0_before", 99, 50, 12'h123);
        pix_check("s0_after", 108, 50, 12'h123);
        pix_check("s0_lastrow", 100, 57, 12'hF00);
        pix_check("s0_below", 100, 58, 12'h123);

        sprite(2'd1, 10'd104, 10'd50, 6'd7, 12'h0F0);
        frame_start();
        pix_check("overlap_prio", 105, 52, 12'hF00);
        pix_check("s1_only", 110, 52, 12'h0F0);

        write_reg(2'd0, 2'd0, 16'd200);
        pix_check("mid_old", 100, 50, 12'hF00);
        pix_check("mid_new", 200, 50, 12'h123);
        videoActiveIn = 1'b0;
        frameStart = 1'b1; regWrite = 1'b1; regAddr = 4'h0; regData = 16'd300;
        tick();
        frameStart = 1'b0; regWrite = 1'b0;
        pix_check("commit_200", 200, 50, 12'hF00);
        pix_check("coinc_pending", 300, 50, 12'h123);
        frame_start();
        pix_check("coinc_applied", 300, 50, 12'hF00);
        pix_check("coinc_old_gone", 200, 50, 12'h123);

        sprite(2'd2, 10'd630, 10'd0, 6'd63, 12'h00F);
        frame_start();
        pix_check("edge_630", 630, 10, 12'h00F);
        pix_check("edge_639", 639, 10, 12'h00F);
        pix_check("edge_629", 629, 10, 12'h123);
        pix_check("nowrap_0", 0, 10, 12'h123);
        pix_check("nowrap_53", 53, 10, 12'h123);

        sprite(2'd3, 10'd635, 10'd5, 6'd3, 12'hFFF);
        frame_start();
        pix_check("s2_over_s3", 636, 6, 12'h00F);
        frame_start();
`ifdef SPRITE_OVERLAY_COLLISION_EN
        exp_coll = 4'b1100; exp_irq = 1'b1;
`else
        exp_coll = 4'b0000; exp_irq = 1'b0;
`endif
        check("coll_flags", collision, exp_coll);
        check("coll_irq", collisionIrq, exp_irq);
        tick();
        check("coll_irq_1cyc", collisionIrq, 1'b0);
        pix_check("no_overlap", 630, 10, 12'h00F);
        frame_start();
        check("coll_clear", collision, 4'b0000);
        check("coll_noirq", collisionIrq, 1'b0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        pix_check("reset_blank", 630, 10, 12'h123);

        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 199);
            reset = (r == 0);
            regWrite = ($urandom_range(0, 3) == 0);
            regAddr = 4'($urandom);
            regData = 16'($urandom);
            if (regAddr[1] == 1'b0) regData[9:0] = 10'($urandom_range(0, 120));
            if (regAddr[1:0] == 2'd3) regData[15] = ($urandom_range(0, 9) < 7);
            videoActiveIn = ($urandom_range(0, 9) != 0);
            frameStart = !videoActiveIn && ($urandom_range(0, 2) == 0);
            hPos = 10'($urandom_range(0, 200));
            vPos = 10'($urandom_range(0, 200));
            if (r < 10) hPos = 10'($urandom_range(0, 1023));
            {bgRed, bgGreen, bgBlue} = 12'($urandom);
            hsyncIn = 1'($urandom);
            vsyncIn = 1'($urandom);
            tick();
        end

        reset = 1'b0; regWrite = 1'b0; frameStart = 1'b0;
        tick();
        tick();
        run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_overlay.md
# sprite_overlay

Downstream pixel stage after the background layer: takes the background's 4:4:4 RGB stream plus aligned timing and overlays up to four solid-colour square sprites. It drives the final VGA pins (red, green, blue, hsync, vsync). Sprite registers are written through a simple CPU-style write port into shadow copies. Shadow copies are committed at frame start so sprites never tear mid-frame.

## Interface
Parameters:
- NUM_SPRITES, 4, number of sprites; fixed at 4, since regAddr encodes a 2-bit sprite index.
- LATENCY, 2, pixel-path latency in clkPixel cycles; informational only, not configurable.

Ports:
- clkPixel  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- bgRed, bgGreen, bgBlue  in  4 each  background pixel colour.
- hsyncIn, vsyncIn, videoActiveIn  in  1 each  timing signals, aligned with bg* on the same cycle.
- hPos, vPos  in  10 each  pixel coordinates, aligned with bg*.
- frameStart  in  1  one-cycle pulse, asserted during vertical blank.
- regWrite  in  1  write strobe.
- regAddr  in  4  [3:2] sprite index, [1:0] field.
- regData  in  16  write data.
- red, green, blue  out  4 each  composited pixel colour.
- hsync, vsync, videoActive  out  1 each  timing, delayed to match the pixel path.
- collision  out  4  per-sprite collision flags from the previous frame.
- collisionIrq  out  1  one-cycle pulse.

## Operation
- Register fields per sprite, written to shadow on any cycle with regWrite=1:
  - field 0: X = regData[9:0].
  - field 1: Y = regData[9:0].
  - field 2: SIZE = regData[5:0]; side length is SIZE+1 pixels (1..64).
  - field 3: COLOR = regData[11:0] as {R,G,B}; EN = regData[15].
- Commit: on a frameStart cycle, active ← shadow as held before that edge. A write on the same cycle lands in shadow only and takes effect at the next frameStart.
- Hit test (11-bit unsigned arithmetic, no wrap):
  - hit_i = EN_i && hPos ≥ X_i && hPos < X_i+SIZE_i+1 && vPos ≥ Y_i && vPos < Y_i+SIZE_i+1.
  - Sprites extending past 639/479 are clipped naturally and never reappear at the left or top edge.
- Priority: the lowest-index hitting sprite wins.
- Output colour:
  - winner's COLOR if any hit_i and videoActiveIn;
  - otherwise bg* if videoActiveIn;
  - otherwise 0.
- Reset:
  - all shadow and active registers cleared (all sprites disabled);
  - pipeline cleared, so after reset the block is a 2-cycle background passthrough.

## Timing
- Pipeline stage 1 registers the hit vector, bg*, and timing signals. Stage 2 registers the muxed RGB and timing outputs.
- Every output changes exactly 2 clkPixel cycles after its input. hsync, vsync and videoActive stay cycle-aligned with RGB.
- Reset values:
  - red, green, blue = 0; videoActive = 0;
  - hsync = 1 and vsync = 1 (idle level of the board's active-low syncs);
  - collision = 0; collisionIrq = 0.
- A register write is visible on the output at the earliest 2 cycles after the next frameStart edge.
- If frameStart and reset coincide, reset wins.
- A mid-frame reset blanks sprites for the remainder of that frame.

## Configuration
- Macro SPRITE_OVERLAY_COLLISION_EN.
- Defined:
  - A 4-bit accumulator ORs in every hit_i on any videoActiveIn cycle where two or more hit_i are set.
  - On frameStart: collision ← accumulator, the accumulator clears, and collisionIrq pulses high for exactly one cycle if the accumulator was nonzero.
- Undefined: the ports remain present; collision ties to 0 and collisionIrq to 0; no accumulator logic is built.

## Test plan
- Reset, then drive bg=0x5A3 with videoActiveIn=1 and no sprites → RGB=0x5A3 two cycles later; hsync/vsync follow their inputs with 2-cycle delay.
- Sprite 0: X=100, Y=50, SIZE=7, COLOR=0xF00, EN=1; write then pulse frameStart.
  - On line vPos=50, pixels hPos=100..107 → 0xF00.
  - hPos=99 and 108 → background.
  - vPos=58 → background.
- Sprites 0 and 1 overlapping, sprite 1 colour 0x0F0, write sprite 1 first → overlap region shows 0xF00 (sprite 0 priority).
- Write sprite 0 X=200 mid-frame without frameStart → old position persists until the next frameStart; a write coincident with frameStart takes effect one frame later.
- Sprite at X=630, SIZE=63 → hits at hPos=630..639 only; nothing drawn at hPos=0..53.
- With SPRITE_OVERLAY_COLLISION_EN, overlap sprites 2 and 3 for one frame → at frameStart collision=4'b1100 and collisionIrq high for 1 cycle; after a frame with no overlap → collision=0 and no pulse.
